// File: rtl/div_share_ctrl.sv
// div_share_ctrl
//   Shares one combinational 4-bit restoring divider between two requesters.
//   A round-robin arbiter picks a channel in IDLE, the granted operands are
//   registered, the divider result is captured at the end of EXEC into that
//   channel's result registers, and RESP raises the channel's DONE pulse.
//   Sequence: IDLE -(grant)-> EXEC -> RESP -> IDLE, one op per 3 cycles max.
//
//   Optional feature: define DIV_ERR_COUNT_EN to add the ERR_CNT_W parameter
//   and the ERR_CNT output, a saturating count of divide-by-zero results.
//
// Ports
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   REQx, Ax, Bx      channel x request and dividend/divisor (x = 0, 1)
//   GNTx              one-cycle pulse: channel x operands accepted
//   DONEx             one-cycle pulse: Qx/Rx/ERRx updated
//   Qx, Rx, ERRx      channel x quotient, remainder, divide-by-zero flag
//   BUSY              high whenever the controller is not idle
//   ERR_CNT           divide-by-zero count (DIV_ERR_COUNT_EN only)
module div_share_ctrl
`ifdef DIV_ERR_COUNT_EN
  #(parameter int ERR_CNT_W = 8)
`endif
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ0,
  input  logic [3:0] A0,
  input  logic [3:0] B0,
  output logic       GNT0,
  output logic       DONE0,
  output logic [3:0] Q0,
  output logic [3:0] R0,
  output logic       ERR0,
  input  logic       REQ1,
  input  logic [3:0] A1,
  input  logic [3:0] B1,
  output logic       GNT1,
  output logic       DONE1,
  output logic [3:0] Q1,
  output logic [3:0] R1,
  output logic       ERR1,
  output logic       BUSY
`ifdef DIV_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] ERR_CNT
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] opa_q, opb_q;
  logic       ch_q;     // channel of the op in flight
  logic       last_q;   // channel granted most recently
  logic [3:0] q0_q, r0_q, q1_q, r1_q;
  logic       err0_q, err1_q;

  // ---------------------------------------------------------------
  // Restoring divider, one stage per dividend bit, MSB first.
  // Each stage shifts in the next dividend bit, trial-subtracts the
  // divisor and restores when the difference goes negative. The
  // partial remainder is always below the divisor, so the 5-bit
  // difference never overflows and its MSB is a true sign bit.
  // ---------------------------------------------------------------
  logic [3:0] rem_stage [0:4];
  logic [3:0] div_q;
  logic [3:0] div_r;
  logic       div_err;

  assign rem_stage[0] = 4'd0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
      logic [4:0] shifted;
      logic [4:0] diff;
      assign shifted = {rem_stage[gi], opa_q[3-gi]};
      assign diff    = shifted - {1'b0, opb_q};
      assign div_q[3-gi]     = ~diff[4];
      assign rem_stage[gi+1] = diff[4] ? shifted[3:0] : diff[3:0];
    end
  endgenerate

  assign div_r   = rem_stage[4];
  assign div_err = (opb_q == 4'd0);

  // ---------------------------------------------------------------
  // Arbitration: a lone request wins; on a tie the channel that was
  // not granted last wins (last_q resets to 1 so channel 0 goes first).
  // ---------------------------------------------------------------
  logic grant0, grant1;

  assign grant0 = (state_q == IDLE) && REQ0 && (!REQ1 || last_q);
  assign grant1 = (state_q == IDLE) && REQ1 && (!REQ0 || !last_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant0 || grant1) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      opa_q   <= 4'd0;
      opb_q   <= 4'd0;
      ch_q    <= 1'b0;
      last_q  <= 1'b1;
      q0_q    <= 4'd0;
      r0_q    <= 4'd0;
      err0_q  <= 1'b0;
      q1_q    <= 4'd0;
      r1_q    <= 4'd0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        opa_q  <= grant1 ? A1 : A0;
        opb_q  <= grant1 ? B1 : B0;
        ch_q   <= grant1;
        last_q <= grant1;
      end
      // Results land at the end of EXEC; a zero divisor reports 0/0.
      if (state_q == EXEC) begin
        if (!ch_q) begin
          q0_q   <= div_err ? 4'd0 : div_q;
          r0_q   <= div_err ? 4'd0 : div_r;
          err0_q <= div_err;
        end else begin
          q1_q   <= div_err ? 4'd0 : div_q;
          r1_q   <= div_err ? 4'd0 : div_r;
          err1_q <= div_err;
        end
      end
    end
  end

`ifdef DIV_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_cnt_q <= '0;
    end else if ((state_q == EXEC) && div_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign ERR_CNT = err_cnt_q;
`endif

  // Pulses are masked while RST is high so that a reset cycle never
  // shows a grant or a completion.
  assign GNT0  = grant0 && !RST;
  assign GNT1  = grant1 && !RST;
  assign DONE0 = (state_q == RESP) && !ch_q && !RST;
  assign DONE1 = (state_q == RESP) &&  ch_q && !RST;
  assign BUSY  = (state_q != IDLE);

  assign Q0   = q0_q;
  assign R0   = r0_q;
  assign ERR0 = err0_q;
  assign Q1   = q1_q;
  assign R1   = r1_q;
  assign ERR1 = err1_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Testbench for div_share_ctrl: directed steps followed by randomized ops,
// checked against a behavioural model built from plain division and the
// round-robin rule.
module tb_div_share_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [3:0] A0 = 4'd0, B0 = 4'd0, A1 = 4'd0, B1 = 4'd0;
  logic       GNT0, DONE0, ERR0, GNT1, DONE1, ERR1, BUSY;
  logic [3:0] Q0, R0, Q1, R1;
`ifdef DIV_ERR_COUNT_EN
  logic [7:0] ERR_CNT;
`endif

  always #5 CLK = ~CLK;

  div_share_ctrl dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .A0(A0), .B0(B0), .GNT0(GNT0), .DONE0(DONE0),
    .Q0(Q0), .R0(R0), .ERR0(ERR0),
    .REQ1(REQ1), .A1(A1), .B1(B1), .GNT1(GNT1), .DONE1(DONE1),
    .Q1(Q1), .R1(R1), .ERR1(ERR1),
    .BUSY(BUSY)
`ifdef DIV_ERR_COUNT_EN
    , .ERR_CNT(ERR_CNT)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0] mq [2];
  logic [3:0] mr [2];
  logic       me [2];
  int         last_m;
  int         errcnt_m;
  localparam int ERR_MAX = 255;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [3:0] a, input logic [3:0] b,
                                  output logic [3:0] q, output logic [3:0] r,
                                  output logic e);
    if (b == 4'd0) begin
      q = 4'd0; r = 4'd0; e = 1'b1;
    end else begin
      q = a / b; r = a % b; e = 1'b0;
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 4'd0; mr[i] = 4'd0; me[i] = 1'b0;
    end
    last_m   = 1;
    errcnt_m = 0;
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_q0"},  16'(Q0),   16'(mq[0]));
    chk({tag, "_r0"},  16'(R0),   16'(mr[0]));
    chk({tag, "_e0"},  16'(ERR0), 16'(me[0]));
    chk({tag, "_q1"},  16'(Q1),   16'(mq[1]));
    chk({tag, "_r1"},  16'(R1),   16'(mr[1]));
    chk({tag, "_e1"},  16'(ERR1), 16'(me[1]));
`ifdef DIV_ERR_COUNT_EN
    chk({tag, "_errcnt"}, 16'(ERR_CNT), 16'(errcnt_m));
`endif
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    #1;
    model_reset();
    chk("rst_busy", 16'(BUSY), 16'(0));
    chk("rst_gnt",  16'({GNT0, GNT1}), 16'(0));
    chk("rst_done", 16'({DONE0, DONE1}), 16'(0));
    chk_results("rst");
    RST = 1'b0;
  endtask

  // One complete operation starting in an IDLE cycle. hold keeps the
  // requests asserted through EXEC/RESP, chg scrambles the operands right
  // after the grant, wd pulses REQ1 during EXEC and drops it in RESP.
  task automatic do_op(input bit r0, input bit r1,
                       input logic [3:0] a0v, input logic [3:0] b0v,
                       input logic [3:0] a1v, input logic [3:0] b1v,
                       input bit hold, input bit chg, input bit wd);
    int ch;
    logic [3:0] eq, er;
    logic ee;
    @(negedge CLK);
    REQ0 = r0; REQ1 = r1; A0 = a0v; B0 = b0v; A1 = a1v; B1 = b1v;
    #1;
    ch = (r0 && r1) ? 1 - last_m : (r0 ? 0 : 1);
    chk("gnt0", 16'(GNT0), 16'(ch == 0));
    chk("gnt1", 16'(GNT1), 16'(ch == 1));
    chk("busy_idle", 16'(BUSY), 16'(0));
    last_m = ch;
    if (ch == 0) ref_div(a0v, b0v, eq, er, ee);
    else         ref_div(a1v, b1v, eq, er, ee);

    @(negedge CLK);
    if (!hold) begin REQ0 = 1'b0; REQ1 = 1'b0; end
    if (wd) REQ1 = 1'b1;
    if (chg) begin
      A0 = 4'($urandom_range(0, 15)); B0 = 4'($urandom_range(0, 15));
      A1 = 4'($urandom_range(0, 15)); B1 = 4'($urandom_range(0, 15));
    end
    #1;
    chk("busy_exec", 16'(BUSY), 16'(1));
    chk("gnt_exec",  16'({GNT0, GNT1}), 16'(0));
    chk("done_exec", 16'({DONE0, DONE1}), 16'(0));

    @(negedge CLK);
    if (wd) REQ1 = 1'b0;
    #1;
    mq[ch] = eq; mr[ch] = er; me[ch] = ee;
    if (ee && errcnt_m < ERR_MAX) errcnt_m++;
    chk("done0", 16'(DONE0), 16'(ch == 0));
    chk("done1", 16'(DONE1), 16'(ch == 1));
    chk("busy_resp", 16'(BUSY), 16'(1));
    chk("gnt_resp",  16'({GNT0, GNT1}), 16'(0));
    chk_results("resp");
    $display("op ch=%0d a=%0d b=%0d -> q=%0d r=%0d err=%0d", ch,
             ch ? a1v : a0v, ch ? b1v : b0v, ch ? Q1 : Q0, ch ? R1 : R0,
             ch ? ERR1 : ERR0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Single op after reset: 13/3 on channel 0, channel 1 untouched.
    do_reset();
    do_op(1, 0, 4'd13, 4'd3, 4'd0, 4'd0, 0, 0, 0);

    // Tie held continuously from reset: 0,1,0,1.
    do_reset();
    for (int i = 0; i < 4; i++)
      do_op(1, 1, 4'd15, 4'd1, 4'd9, 4'd4, 1, 0, 0);

    // Divide by zero on channel 1.
    do_op(0, 1, 4'd0, 4'd0, 4'd7, 4'd0, 0, 0, 0);

    // Operand change right after the grant.
    do_op(1, 0, 4'd8, 4'd2, 4'd0, 4'd0, 0, 1, 0);

    // REQ1 withdrawn before channel 1 could be granted.
    do_op(1, 0, 4'd11, 4'd5, 4'd0, 4'd0, 0, 0, 1);

    // Reset during EXEC drops the op.
    @(negedge CLK);
    REQ0 = 1'b1; A0 = 4'd9; B0 = 4'd2;
    #1;
    chk("midrst_gnt0", 16'(GNT0), 16'(1));
    @(negedge CLK);
    REQ0 = 1'b0; RST = 1'b1;
    #1;
    chk("midrst_exec_done", 16'({DONE0, DONE1}), 16'(0));
    @(negedge CLK);
    #1;
    model_reset();
    chk("midrst_done", 16'({DONE0, DONE1}), 16'(0));
    chk("midrst_busy", 16'(BUSY), 16'(0));
    chk_results("midrst");
    RST = 1'b0;
    // Next tie must go to channel 0.
    do_op(1, 1, 4'd9, 4'd2, 4'd6, 4'd3, 0, 0, 0);

    // Randomized ops.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] pat;
      logic [3:0] ra0, rb0, ra1, rb1;
      pat = 2'($urandom_range(1, 3));
      ra0 = 4'($urandom_range(0, 15));
      ra1 = 4'($urandom_range(0, 15));
      rb0 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rb1 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      do_op(pat[0], pat[1], ra0, rb0, ra1, rb1,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

`ifdef DIV_ERR_COUNT_EN
    // Counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++)
      do_op(0, 1, 4'd0, 4'd0, 4'd7, 4'd0, 0, 0, 0);
    chk("errcnt_sat", 16'(ERR_CNT), 16'(ERR_MAX));
`endif

    @(negedge CLK);
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    #1;
    chk("final_busy", 16'(BUSY), 16'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
Two-channel controller that shares one combinational 4x4 restoring divider (Divisor4Bits) between two requesters. It runs a round-robin arbiter, registers the granted operands into the divider, and captures Q/R/ERR into per-channel result registers. It signals completion with a one-cycle DONE pulse. It sits between the two operand sources (e.g. ALU and display formatter) and the shared divider.

Parameters:
ERR_CNT_W, 8, width of the divide-by-zero event counter (used only when DIV_ERR_COUNT_EN is defined)

Ports:
CLK  in  1  single system clock, rising-edge
RST  in  1  synchronous reset, active-high
REQ0  in  1  channel 0 request; held until GNT0
A0  in  4  channel 0 dividend, valid while REQ0=1
B0  in  4  channel 0 divisor, valid while REQ0=1
GNT0  out  1  one-cycle pulse: channel 0 operands accepted
DONE0  out  1  one-cycle pulse: Q0/R0/ERR0 updated
Q0  out  4  channel 0 quotient, held until next DONE0
R0  out  4  channel 0 remainder, held until next DONE0
ERR0  out  1  channel 0 divide-by-zero flag, held until next DONE0
REQ1, A1, B1, GNT1, DONE1, Q1, R1, ERR1  same as channel 0, for channel 1
BUSY  out  1  1 whenever FSM not in IDLE
ERR_CNT  out  ERR_CNT_W  saturating count of ERR results (present only with DIV_ERR_COUNT_EN)

Behaviour:
- Interface: one clock CLK; RST is synchronous and active-high. All state changes occur on the rising edge of CLK.
- Reset values: GNT0/1=0, DONE0/1=0, Q0/Q1=0, R0/R1=0, ERR0/ERR1=0, BUSY=0, FSM=IDLE, operand regs=0, LAST=1 (so channel 0 wins the first tie), ERR_CNT=0.
- The FSM has three states: IDLE -> EXEC -> RESP -> IDLE. It never stalls.
- IDLE, arbitration:
  - Only REQ0=1: grant channel 0.
  - Only REQ1=1: grant channel 1.
  - Both high: grant the channel != LAST.
  - Neither high: stay in IDLE.
- On grant:
  - GNTx=1 for that cycle.
  - OPA<=Ax, OPB<=Bx, CH<=x, LAST<=x.
  - Next state EXEC.
- EXEC: the divider is driven only from OPA/OPB, never from the live A/B inputs. At the end of EXEC, the result is latched into the CH result registers:
  - Qx<=divider Q, Rx<=divider R, ERRx<=divider ERR.
  - If ERR=1, Qx and Rx are forced to 0.
  - The other channel's result registers are untouched.
  - Next state RESP.
- RESP: DONE(CH)=1 for exactly one cycle. Next state IDLE.
- Latency and throughput:
  - Request sampled with GNT at cycle t; DONE at cycle t+2; the new result is visible at t+2.
  - Next grant no earlier than t+3, so maximum throughput is one op per 3 cycles.
- Handshake rules:
  - A requester may drop REQ before GNT (withdraw); this is legal and nothing is recorded.
  - REQ still high in the cycle after GNT is treated as a new request, evaluated at the next IDLE.
  - Operand changes after GNT have no effect on the in-flight op.
  - GNT0 and GNT1 are never high together; DONE0 and DONE1 are never high together.
- BUSY = (state != IDLE); it is combinational from the state register.
- Reset mid-operation (RST in EXEC or RESP): the in-flight op is dropped, no DONE is issued, and all outputs return to their reset values on the next edge.
- Starvation bound: with both REQ held continuously, grants alternate 0,1,0,1,...

Optional Feature:
Macro DIV_ERR_COUNT_EN.
- Defined: ERR_CNT port and register exist.
  - Increments by 1 in each EXEC cycle whose result has ERR=1, from either channel.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - Cleared only by RST.
- Undefined: no ERR_CNT port and no counter logic. All other behaviour is identical.

Test Plan:
- Single op: REQ0=1, A0=13, B0=3 -> GNT0 at t, DONE0 at t+2, Q0=4, R0=1, ERR0=0; Q1/R1 remain 0.
- Tie after reset: REQ0=REQ1=1 held continuously, A0=15, B0=1, A1=9, B1=4 -> grants 0,1,0,1 at 3-cycle spacing. Ch0 gets Q0=15, R0=0; ch1 gets Q1=2, R1=1; DONEs never overlap.
- Divide by zero: REQ1=1, A1=7, B1=0 -> DONE1 at t+2, ERR1=1, Q1=0, R1=0. With DIV_ERR_COUNT_EN, ERR_CNT goes 0->1. Repeating 300 times with ERR_CNT_W=8 stops ERR_CNT at 255.
- Operand change after grant: REQ0=1, A0=8, B0=2, then A0=15, B0=1 at t+1 -> Q0=4, R0=0.
- Reset mid-op: grant ch0 (A0=9, B0=2), assert RST during EXEC -> no DONE0; next cycle Q0=0, R0=0, BUSY=0. The next tie is granted to channel 0.
- Withdraw: REQ1 pulsed high during EXEC of a ch0 op and low before IDLE -> no GNT1, no DONE1, R1/Q1 unchanged.
